proc_mem_responder: RTL and testbench

Unified instruction/data memory responder serving the pipelined core's instruction-fetch port (`pc_addr`/`im_command`/`instruction`) and data port (`proc2Dmem_*`/`mem2proc_data`). It answers `BUS_LOAD` with a same-cycle word and commits `BUS_STORE` on the clock edge. A boot loader FSM holds the core in reset while a program image is streamed in over a valid/ready port. It also records stores and flags illegal accesses.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_word_array.sv | 29 ++
 rtl/proc_mem_responder.sv | 159 +++++++++++++++
 tb/tb_proc_mem_responder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared bus encodings, constants and FSM state type for the memory responder.
package mem_pkg;

    localparam logic [1:0]  BUS_NONE  = 2'h0;
    localparam logic [1:0]  BUS_LOAD  = 2'h1;
    localparam logic [1:0]  BUS_STORE = 2'h2;

    localparam logic [31:0] NOOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_DRAIN = 2'd1,
        S_RUN   = 2'd2
    } mem_state_t;

    // Word-aligned and inside the array: low two bits clear, nothing above the index.
    function automatic logic addr_legal(input logic [31:0] addr, input int unsigned idx_w);
        logic [31:0] hi;
        hi = addr >> (idx_w + 32'd2);
        return (addr[1:0] == 2'b00) && (hi == 32'd0);
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word array with two combinational read ports and one synchronous write port.
module mem_word_array #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic [IDX_W-1:0]  ridx_a,
    output logic [31:0]       rdata_a,
    input  logic [IDX_W-1:0]  ridx_b,
    output logic [31:0]       rdata_b,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [31:0]       wdata
);

    // Storage has no reset so contents survive a mid-run reset.
    logic [31:0] mem [MEM_WORDS];

    // Commit a write on the edge; same-cycle reads still see the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata_a = mem[ridx_a];
    assign rdata_b = mem[ridx_b];

endmodule

// File: rtl/proc_mem_responder.sv
// Unified instruction/data memory responder with a boot loader that holds the core in reset.
module proc_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_addr,
    input  logic [1:0]  im_command,
    output logic [31:0] instruction,
    input  logic [31:0] proc2Dmem_addr,
    input  logic [1:0]  proc2Dmem_command,
    input  logic [31:0] proc2mem_data,
    output logic [31:0] mem2proc_data,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        core_rst,
    output logic        mem_fault,
    output logic [15:0] store_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_WORDS - 1);

    mem_state_t       state_q;
    mem_state_t       state_d;
    logic [IDX_W-1:0] ld_ptr_q;
    logic [IDX_W-1:0] ld_ptr_d;
    logic             core_rst_q;
    logic             mem_fault_q;
    logic [15:0]      store_count_q;

    logic             run_c;
    logic             im_legal_c;
    logic             dm_legal_c;
    logic             im_load_c;
    logic             im_access_c;
    logic             dm_load_c;
    logic             dm_store_c;
    logic             dm_access_c;
    logic             ld_accept_c;
    logic             store_ok_c;
    logic             fault_evt_c;
    logic [IDX_W-1:0] im_idx_c;
    logic [IDX_W-1:0] dm_idx_c;

    logic             we_c;
    logic [IDX_W-1:0] widx_c;
    logic [31:0]      wdata_c;
    logic [31:0]      rdata_im;
    logic [31:0]      rdata_dm;

    // Command and address decode for both processor ports.
    assign run_c       = (state_q == S_RUN);
    assign im_legal_c  = addr_legal(pc_addr, IDX_W);
    assign dm_legal_c  = addr_legal(proc2Dmem_addr, IDX_W);
    assign im_idx_c    = pc_addr[IDX_W+1:2];
    assign dm_idx_c    = proc2Dmem_addr[IDX_W+1:2];
    assign im_load_c   = (im_command == BUS_LOAD);
    assign im_access_c = im_load_c || (im_command == BUS_STORE);
    assign dm_load_c   = (proc2Dmem_command == BUS_LOAD);
    assign dm_store_c  = (proc2Dmem_command == BUS_STORE);
    assign dm_access_c = dm_load_c || dm_store_c;

    // Loader handshake is only open in S_LOAD and is held low during reset.
    assign ld_ready    = (state_q == S_LOAD) && !rst;
    assign ld_accept_c = ld_valid && ld_ready;

    assign store_ok_c  = run_c && dm_store_c && dm_legal_c;
    assign fault_evt_c = run_c && ((im_access_c && !im_legal_c) ||
                                   (dm_access_c && !dm_legal_c));

    // Single write port: the loader owns it in S_LOAD, the data port afterwards.
    always_comb begin
        we_c    = 1'b0;
        widx_c  = dm_idx_c;
        wdata_c = proc2mem_data;
        if (state_q == S_LOAD) begin
            we_c    = ld_accept_c;
            widx_c  = ld_ptr_q;
            wdata_c = ld_data;
        end else begin
            we_c    = store_ok_c;
        end
    end

    mem_word_array #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk     (clk),
        .ridx_a  (im_idx_c),
        .rdata_a (rdata_im),
        .ridx_b  (dm_idx_c),
        .rdata_b (rdata_dm),
        .we      (we_c),
        .widx    (widx_c),
        .wdata   (wdata_c)
    );

    // Zero-latency read returns; commands are ignored until the core is running.
    assign instruction   = (run_c && im_load_c && im_legal_c) ? rdata_im : NOOP_INST;
    assign mem2proc_data = (run_c && dm_load_c && dm_legal_c) ? rdata_dm : 32'h0;

    // Next-state logic for the boot FSM and loader pointer.
    always_comb begin
        state_d  = state_q;
        ld_ptr_d = ld_ptr_q;
        unique case (state_q)
            S_LOAD: begin
                if (ld_accept_c) begin
                    ld_ptr_d = ld_ptr_q + IDX_W'(1);
                    if (ld_last || (ld_ptr_q == LAST_IDX)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_LOAD;
        endcase
    end

    // State, pointer and registered core reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LOAD;
            ld_ptr_q   <= '0;
            core_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            ld_ptr_q   <= ld_ptr_d;
            core_rst_q <= (state_d != S_RUN);
        end
    end

    // Sticky fault flag and saturating store counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_fault_q   <= 1'b0;
            store_count_q <= 16'h0;
        end else begin
            if (fault_evt_c) begin
                mem_fault_q <= 1'b1;
            end
            if (store_ok_c && (store_count_q != 16'hFFFF)) begin
                store_count_q <= store_count_q + 16'd1;
            end
        end
    end

    assign core_rst    = core_rst_q;
    assign mem_fault   = mem_fault_q;
    assign store_count = store_count_q;

endmodule

// File: tb/tb_proc_mem_responder.sv
// Scoreboard bench for proc_mem_responder: a 1024-word instance and a 4-word instance.
module tb_proc_mem_responder;
    import mem_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 1024-word instance
    logic        rst;
    logic [31:0] pc_addr;
    logic [1:0]  im_command;
    logic [31:0] instruction;
    logic [31:0] dm_addr;
    logic [1:0]  dm_cmd;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        core_rst;
    logic        mem_fault;
    logic [15:0] store_count;

    // 4-word instance
    logic        rst4;
    logic [31:0] pc_addr4;
    logic [1:0]  im_command4;
    logic [31:0] instruction4;
    logic [31:0] dm_addr4;
    logic [1:0]  dm_cmd4;
    logic [31:0] dm_wdata4;
    logic [31:0] dm_rdata4;
    logic        ld_valid4;
    logic [31:0] ld_data4;
    logic        ld_last4;
    logic        ld_ready4;
    logic        core_rst4;
    logic        mem_fault4;
    logic [15:0] store_count4;

    proc_mem_responder #(.MEM_WORDS(1024)) dut (
        .clk(clk), .rst(rst),
        .pc_addr(pc_addr), .im_command(im_command), .instruction(instruction),
        .proc2Dmem_addr(dm_addr), .proc2Dmem_command(dm_cmd),
        .proc2mem_data(dm_wdata), .mem2proc_data(dm_rdata),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .core_rst(core_rst), .mem_fault(mem_fault), .store_count(store_count)
    );

    proc_mem_responder #(.MEM_WORDS(4)) dut4 (
        .clk(clk), .rst(rst4),
        .pc_addr(pc_addr4), .im_command(im_command4), .instruction(instruction4),
        .proc2Dmem_addr(dm_addr4), .proc2Dmem_command(dm_cmd4),
        .proc2mem_data(dm_wdata4), .mem2proc_data(dm_rdata4),
        .ld_valid(ld_valid4), .ld_data(ld_data4), .ld_last(ld_last4), .ld_ready(ld_ready4),
        .core_rst(core_rst4), .mem_fault(mem_fault4), .store_count(store_count4)
    );

    localparam int O_INST   = 0;
    localparam int O_DRD    = 1;
    localparam int O_CRST   = 2;
    localparam int O_RDY    = 3;
    localparam int O_FAULT  = 4;
    localparam int O_CNT    = 5;
    localparam int O_INST4  = 6;
    localparam int O_RDY4   = 7;
    localparam int O_CRST4  = 8;

    int          n_vec = 0;
    int          n_err = 0;

    string       q_tag [$];
    int          q_sel [$];
    logic [31:0] q_exp [$];

    logic [31:0] img  [4];
    logic [31:0] img4 [4];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            O_INST:  return instruction;
            O_DRD:   return dm_rdata;
            O_CRST:  return 32'(core_rst);
            O_RDY:   return 32'(ld_ready);
            O_FAULT: return 32'(mem_fault);
            O_CNT:   return 32'(store_count);
            O_INST4: return instruction4;
            O_RDY4:  return 32'(ld_ready4);
            O_CRST4: return 32'(core_rst4);
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic expect_out(input int sel, input string tag, input logic [31:0] exp);
        q_sel.push_back(sel);
        q_tag.push_back(tag);
        q_exp.push_back(exp);
    endtask

    // Sample away from the active edge and retire every queued expectation.
    task automatic sb_check();
        int    sel;
        string tag;
        logic [31:0] exp;
        @(negedge clk);
        while (q_sel.size() > 0) begin
            sel = q_sel.pop_front();
            tag = q_tag.pop_front();
            exp = q_exp.pop_front();
            check_val(tag, observe(sel), exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        img[0]  = 32'h0000_0013; img[1]  = 32'h0010_0093;
        img[2]  = 32'h0020_0113; img[3]  = 32'hDEAD_BEEF;
        img4[0] = 32'hA000_0000; img4[1] = 32'hA111_1111;
        img4[2] = 32'hA222_2222; img4[3] = 32'hA333_3333;

        rst = 1'b1; pc_addr = 32'h0; im_command = BUS_LOAD;
        dm_addr = 32'h4; dm_cmd = BUS_LOAD; dm_wdata = 32'h0;
        ld_valid = 1'b0; ld_data = 32'h0; ld_last = 1'b0;
        rst4 = 1'b1; pc_addr4 = 32'h0; im_command4 = BUS_NONE;
        dm_addr4 = 32'h0; dm_cmd4 = BUS_NONE; dm_wdata4 = 32'h0;
        ld_valid4 = 1'b0; ld_data4 = 32'h0; ld_last4 = 1'b0;

        // Reset values
        repeat (2) tick();
        expect_out(O_INST,  "rst_inst",  NOOP_INST);
        expect_out(O_DRD,   "rst_drd",   32'h0);
        expect_out(O_CRST,  "rst_crst",  32'd1);
        expect_out(O_RDY,   "rst_rdy",   32'd0);
        expect_out(O_FAULT, "rst_fault", 32'd0);
        expect_out(O_CNT,   "rst_cnt",   32'd0);
        sb_check();

        tick(); rst = 1'b0;
        expect_out(O_RDY,  "load_rdy",  32'd1);
        expect_out(O_CRST, "load_crst", 32'd1);
        sb_check();

        // Stream the boot image; processor commands are ignored meanwhile
        for (int i = 0; i < 4; i++) begin
            tick();
            ld_valid = 1'b1; ld_data = img[i]; ld_last = (i == 3);
            pc_addr = 32'h4;
            if (i == 2) begin
                expect_out(O_INST, "load_inst_noop", NOOP_INST);
                expect_out(O_DRD,  "load_drd_zero",  32'h0);
            end
            sb_check();
        end
        tick(); ld_valid = 1'b0; ld_last = 1'b0;
        expect_out(O_CRST, "drain_crst", 32'd1);
        expect_out(O_RDY,  "drain_rdy",  32'd0);
        sb_check();
        tick();
        pc_addr = 32'hC; im_command = BUS_LOAD; dm_addr = 32'h4; dm_cmd = BUS_LOAD;
        expect_out(O_CRST, "run_crst",  32'd0);
        expect_out(O_RDY,  "run_rdy",   32'd0);
        expect_out(O_INST, "run_fetch_c", 32'hDEAD_BEEF);
        expect_out(O_DRD,  "run_load_4",  32'h0010_0093);
        sb_check();

        // Stores, read-during-write on the fetch port
        tick(); dm_cmd = BUS_STORE; dm_addr = 32'h40; dm_wdata = 32'hAAAA_5555;
        im_command = BUS_NONE; pc_addr = 32'hC;
        expect_out(O_INST, "none_noop", NOOP_INST);
        sb_check();
        tick(); dm_cmd = BUS_NONE; im_command = BUS_LOAD; pc_addr = 32'h40;
        expect_out(O_CNT,   "st1_cnt",   32'd1);
        expect_out(O_FAULT, "st1_fault", 32'd0);
        expect_out(O_INST,  "st1_fetch", 32'hAAAA_5555);
        sb_check();
        tick(); dm_cmd = BUS_STORE; dm_addr = 32'h40; dm_wdata = 32'h1234_5678;
        expect_out(O_INST, "rdw_old", 32'hAAAA_5555);
        sb_check();
        tick(); dm_cmd = BUS_LOAD;
        expect_out(O_DRD,  "rdw_new_d", 32'h1234_5678);
        expect_out(O_INST, "rdw_new_i", 32'h1234_5678);
        expect_out(O_CNT,  "st2_cnt",   32'd2);
        sb_check();
        tick(); dm_cmd = BUS_STORE; dm_addr = 32'h8; dm_wdata = 32'hCAFE_F00D; pc_addr = 32'h8;
        expect_out(O_INST, "rdw8_old", 32'h0020_0113);
        sb_check();
        tick(); dm_cmd = BUS_LOAD;
        expect_out(O_DRD,   "rdw8_new_d", 32'hCAFE_F00D);
        expect_out(O_INST,  "rdw8_new_i", 32'hCAFE_F00D);
        expect_out(O_CNT,   "st3_cnt",    32'd3);
        expect_out(O_FAULT, "st3_fault",  32'd0);
        sb_check();

        // Illegal accesses
        tick(); dm_cmd = BUS_STORE; dm_addr = 32'h42; dm_wdata = 32'hBADB_AD00; pc_addr = 32'h40;
        expect_out(O_INST,  "mis_fetch",  32'h1234_5678);
        expect_out(O_FAULT, "mis_pre",    32'd0);
        sb_check();
        tick(); dm_cmd = BUS_LOAD; dm_addr = 32'h40;
        expect_out(O_DRD,   "mis_dropped", 32'h1234_5678);
        expect_out(O_FAULT, "mis_fault",   32'd1);
        expect_out(O_CNT,   "mis_cnt",     32'd3);
        sb_check();
        tick(); dm_addr = 32'h0000_1000; pc_addr = 32'h6;
        expect_out(O_DRD,   "oor_load",  32'h0);
        expect_out(O_INST,  "mis_inst",  NOOP_INST);
        expect_out(O_FAULT, "fault_hold1", 32'd1);
        sb_check();
        tick(); dm_cmd = 2'h3; dm_addr = 32'h42; im_command = BUS_NONE;
        expect_out(O_DRD, "cmd3_drd", 32'h0);
        sb_check();
        repeat (3) tick();
        expect_out(O_FAULT, "fault_hold2", 32'd1);
        sb_check();

        // Reset mid-load: partial reload then a fresh one from word 0
        tick(); rst = 1'b1; dm_cmd = BUS_NONE; im_command = BUS_NONE;
        expect_out(O_CRST,  "rst2_crst",  32'd1);
        expect_out(O_RDY,   "rst2_rdy",   32'd0);
        expect_out(O_FAULT, "rst2_fault", 32'd0);
        expect_out(O_CNT,   "rst2_cnt",   32'd0);
        sb_check();
        tick(); rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            ld_valid = 1'b1; ld_data = (i == 0) ? 32'h1111_1111 : 32'h2222_2222; ld_last = 1'b0;
            sb_check();
        end
        tick(); ld_valid = 1'b0; rst = 1'b1;
        expect_out(O_CRST, "midrst_crst", 32'd1);
        sb_check();
        tick(); rst = 1'b0;
        expect_out(O_RDY,  "reload_rdy",  32'd1);
        expect_out(O_CRST, "reload_crst", 32'd1);
        sb_check();
        tick(); ld_valid = 1'b1; ld_data = 32'h3333_3333; ld_last = 1'b1;
        sb_check();
        tick(); ld_valid = 1'b0; ld_last = 1'b0;
        sb_check();
        tick(); im_command = BUS_LOAD; pc_addr = 32'h0; dm_cmd = BUS_LOAD; dm_addr = 32'h4;
        expect_out(O_CRST, "reload_run",  32'd0);
        expect_out(O_INST, "reload_w0",   32'h3333_3333);
        expect_out(O_DRD,  "reload_w1",   32'h2222_2222);
        sb_check();
        tick(); pc_addr = 32'h8; dm_addr = 32'h40;
        expect_out(O_INST, "kept_w2",  32'hCAFE_F00D);
        expect_out(O_DRD,  "kept_w16", 32'h1234_5678);
        sb_check();
        tick(); pc_addr = 32'h0000_1000; dm_cmd = BUS_NONE;
        expect_out(O_INST,  "ifault_inst", NOOP_INST);
        expect_out(O_FAULT, "ifault_pre",  32'd0);
        sb_check();
        tick(); im_command = BUS_NONE;
        expect_out(O_FAULT, "ifault_set", 32'd1);
        sb_check();

        // Loader overflow on the 4-word instance
        tick(); rst4 = 1'b0;
        expect_out(O_RDY4, "ovf_rdy_open", 32'd1);
        sb_check();
        for (int i = 0; i < 4; i++) begin
            tick();
            ld_valid4 = 1'b1; ld_data4 = img4[i]; ld_last4 = 1'b0;
            if (i == 3) expect_out(O_RDY4, "ovf_rdy_w4", 32'd1);
            sb_check();
        end
        tick(); ld_data4 = 32'hFFFF_FFFF;
        expect_out(O_RDY4,  "ovf_rdy_drop", 32'd0);
        expect_out(O_CRST4, "ovf_drain",    32'd1);
        sb_check();
        tick(); im_command4 = BUS_LOAD; pc_addr4 = 32'hC;
        expect_out(O_CRST4, "ovf_run",   32'd0);
        expect_out(O_INST4, "ovf_w3",    32'hA333_3333);
        sb_check();
        tick(); pc_addr4 = 32'h0;
        expect_out(O_INST4, "ovf_w0_held", 32'hA000_0000);
        sb_check();
        tick(); pc_addr4 = 32'h10; ld_valid4 = 1'b0;
        expect_out(O_INST4, "ovf_oor", NOOP_INST);
        sb_check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
